// File: rtl/if_id_hazard_controller_if.sv
// IF/ID hazard controller bus: decode-stage hazard inputs in, pipeline control out.
// master = pipeline/testbench side, slave = hazard controller.
interface if_id_hazard_controller_if;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;
    logic        MemRead_EX;
    logic [4:0]  Rt_EX;
    logic        Branch_Taken_ID;
    logic        Jump_ID;
    logic        MulDiv_Start_ID;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Bubble;
    logic        MulDiv_Busy;
    logic [15:0] Stall_Cycles;

    modport master (
        output Rs_ID, Rt_ID, MemRead_EX, Rt_EX, Branch_Taken_ID, Jump_ID, MulDiv_Start_ID,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulDiv_Busy, Stall_Cycles
    );

    modport slave (
        input  Rs_ID, Rt_ID, MemRead_EX, Rt_EX, Branch_Taken_ID, Jump_ID, MulDiv_Start_ID,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulDiv_Busy, Stall_Cycles
    );
endinterface

// File: rtl/if_id_hazard_controller.sv
// IF/ID hazard controller: load-use stall, branch/jump flush, optional multi-cycle
// mul/div stall enabled by macro HAZARD_MULDIV_STALL_EN.
module if_id_hazard_controller #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic                         Clk,
    input  logic                         Reset,
    if_id_hazard_controller_if.slave     bus
);

    typedef enum logic {RUN, MULDIV_WAIT} state_t;

    state_t      state;
    logic        lu, ct;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [15:0] stall_cnt;

    assign lu = bus.MemRead_EX && (bus.Rt_EX != 5'd0) &&
                ((bus.Rt_EX == bus.Rs_ID) || (bus.Rt_EX == bus.Rt_ID));
    assign ct = bus.Branch_Taken_ID || bus.Jump_ID;

    // Load-use outranks control transfer; the branch is seen again once the stall clears.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (Reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state == MULDIV_WAIT || lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (ct) begin
            if_id_flush  = 1'b1;
        end
    end

`ifdef HAZARD_MULDIV_STALL_EN
    localparam logic [5:0] WAIT_LOAD = 6'(MULDIV_CYCLES - 2);

    state_t     state_nxt;
    logic [5:0] wait_cnt, wait_cnt_nxt;

    // Wait_Cnt counts N-2..0, giving N-1 stalled cycles after the issuing cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (!lu && bus.MulDiv_Start_ID) begin
                    state_nxt    = MULDIV_WAIT;
                    wait_cnt_nxt = WAIT_LOAD;
                end
            end
            MULDIV_WAIT: begin
                if (wait_cnt == 6'd0) state_nxt = RUN;
                else                  wait_cnt_nxt = wait_cnt - 6'd1;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= RUN;
            wait_cnt <= 6'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign bus.MulDiv_Busy = (state == MULDIV_WAIT);
`else
    logic unused_muldiv;

    assign state           = RUN;
    assign bus.MulDiv_Busy = 1'b0;
    assign unused_muldiv   = bus.MulDiv_Start_ID;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            stall_cnt <= 16'd0;
        else if (!pc_write && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign bus.PC_Write     = pc_write;
    assign bus.IF_ID_Write  = if_id_write;
    assign bus.IF_ID_Flush  = if_id_flush;
    assign bus.ID_EX_Bubble = id_ex_bubble;
    assign bus.Stall_Cycles = stall_cnt;

endmodule
